// File: rtl/audio_i2s_tx.sv
// ----------------------------------------------------------------------------
// audio_i2s_tx
//
// Audio output stage. 32-bit chunks arriving from the audio controller are
// buffered in a small FIFO. Each chunk is sent to an external I2S DAC as one
// 16-bit stereo frame: chunk[31:16] is the left sample and chunk[15:0] is the
// right sample, both MSB first. BCLK and LRCLK are derived from clk.
//
// Parameters
//   FIFO_DEPTH  FIFO entries of 32 bits (power of 2, >= 2)
//   BCLK_DIV    clk cycles per BCLK half-period (>= 2)
//
// Ports
//   clk           in   system clock
//   rst_n         in   synchronous, active-low reset
//   wr_valid      in   chunk valid from the audio controller
//   wr_data       in   chunk {left[15:0], right[15:0]}
//   wr_ready      out  FIFO can accept; a write happens on wr_valid & wr_ready
//   enable        in   play (1) / mute-and-hold (0); only looked at on frame load
//   flush         in   discard every buffered chunk
//   fifo_level    out  current number of FIFO entries
//   underrun      out  1-cycle pulse: a frame started while enabled with the FIFO empty
//   i2s_bclk      out  bit clock
//   i2s_lrclk     out  word select, 0 = left
//   i2s_sdata     out  serial data, MSB first
//   underrun_cnt  out  saturating underrun count (only with AUDIO_UNDERRUN_CNT_EN)
//
// Build option
//   AUDIO_UNDERRUN_CNT_EN  when defined, adds the underrun_cnt port and its
//                          16-bit saturating counter (cleared by reset or flush).
//                          When undefined, the port and counter do not exist.
// ----------------------------------------------------------------------------
module audio_i2s_tx #(
    parameter int FIFO_DEPTH = 8,
    parameter int BCLK_DIV   = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_valid,
    input  logic [31:0]                   wr_data,
    output logic                          wr_ready,
    input  logic                          enable,
    input  logic                          flush,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun,
    output logic                          i2s_bclk,
    output logic                          i2s_lrclk,
    output logic                          i2s_sdata
`ifdef AUDIO_UNDERRUN_CNT_EN
    ,
    output logic [15:0]                   underrun_cnt
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int DIV_W = $clog2(BCLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [4:0]       BCNT_LAST = 5'd31;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt_q,  div_cnt_d;
    logic             bclk_q,     bclk_d;
    logic [4:0]       bcnt_q,     bcnt_d;
    logic             lrclk_q,    lrclk_d;
    logic [31:0]      shift_q,    shift_d;
    logic             underrun_q, underrun_d;

    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [LVL_W-1:0] count_q,    count_d;
    logic [31:0]      mem_q [FIFO_DEPTH];

    // ------------------------------------------------------------------
    // Events
    // ------------------------------------------------------------------
    logic bclk_toggle;
    logic bclk_fall;
    logic frame_load;
    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic pop;

    always_comb begin
        bclk_toggle = (div_cnt_q == DIV_LAST);
        bclk_fall   = bclk_toggle & bclk_q;
        frame_load  = bclk_fall & (bcnt_q == BCNT_LAST);

        // Full/empty come from the registered count only, so a same-cycle
        // pop never makes room for a write and a same-cycle write never
        // feeds a pop.
        fifo_empty  = (count_q == '0);
        fifo_full   = (count_q == LVL_FULL);

        wr_ready    = ~fifo_full & ~flush;
        push        = wr_valid & wr_ready;
        // A flush coinciding with a frame load discards the head as well,
        // so that frame plays silence.
        pop         = frame_load & enable & ~fifo_empty & ~flush;
    end

    // ------------------------------------------------------------------
    // Bit clock generation: free-running regardless of enable
    // ------------------------------------------------------------------
    always_comb begin
        div_cnt_d = bclk_toggle ? '0 : div_cnt_q + DIV_W'(1);
        bclk_d    = bclk_toggle ? ~bclk_q : bclk_q;
    end

    // ------------------------------------------------------------------
    // Serializer: everything advances on the BCLK falling edge so the DAC
    // sees stable data and word select at each rising edge.
    // ------------------------------------------------------------------
    always_comb begin
        bcnt_d     = bclk_fall ? bcnt_q + 5'd1 : bcnt_q;
        // Word select leads the data by one bit: high for slots 15..30.
        lrclk_d    = (bcnt_d >= 5'd15) && (bcnt_d != BCNT_LAST);
        underrun_d = frame_load & enable & (fifo_empty | flush);

        shift_d = shift_q;
        if (frame_load) begin
            shift_d = pop ? mem_q[rd_ptr_q] : 32'h0;
        end else if (bclk_fall) begin
            shift_d = {shift_q[30:0], 1'b0};
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointers and level
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + LVL_W'(push) - LVL_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt_q  <= '0;
            bclk_q     <= 1'b0;
            bcnt_q     <= BCNT_LAST;
            lrclk_q    <= 1'b0;
            shift_q    <= 32'h0;
            underrun_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            bclk_q     <= bclk_d;
            bcnt_q     <= bcnt_d;
            lrclk_q    <= lrclk_d;
            shift_q    <= shift_d;
            underrun_q <= underrun_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset; the level and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

`ifdef AUDIO_UNDERRUN_CNT_EN
    // ------------------------------------------------------------------
    // Saturating underrun counter
    // ------------------------------------------------------------------
    logic [15:0] underrun_cnt_q, underrun_cnt_d;

    always_comb begin
        underrun_cnt_d = underrun_cnt_q;
        if (flush) begin
            underrun_cnt_d = 16'h0;
        end else if (underrun_d && (underrun_cnt_q != 16'hFFFF)) begin
            underrun_cnt_d = underrun_cnt_q + 16'h1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            underrun_cnt_q <= 16'h0;
        end else begin
            underrun_cnt_q <= underrun_cnt_d;
        end
    end

    assign underrun_cnt = underrun_cnt_q;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign fifo_level = count_q;
    assign underrun   = underrun_q;
    assign i2s_bclk   = bclk_q;
    assign i2s_lrclk  = lrclk_q;
    assign i2s_sdata  = shift_q[31];

endmodule
